// File: rtl/conv1d_mem_scheduler.sv
// Conv1D memory scheduler: walks every (output, weight) pair, stages reads through the
// L0 ping-pong buffers via a 4-stage tag pipeline and writes each finished output back.
module conv1d_mem_scheduler #(
  parameter int Weight_Nums       = 3,
  parameter int Input_Nums        = 16,
  parameter int Output_Nums       = Input_Nums - Weight_Nums + 1,
  parameter int Weight_Addr_Width = 2,
  parameter int Input_Addr_Width  = 4,
  parameter int Output_Addr_Width = 4,
  parameter int Nums_SRAM         = 3,
  parameter int Step_Width        = 6
) (
  input  logic                         clk,
  input  logic                         Mem_Reset,
  input  logic                         Start,
  output logic                         Busy,
  output logic                         Done,
  output logic [Nums_SRAM-1:0]         Mem_Clear,
  output logic [Nums_SRAM-1:0]         Mem_CS,
  output logic [Nums_SRAM-1:0]         Mem_En_W,
  output logic [Nums_SRAM-1:0]         Mem_En_R,
  output logic [Nums_SRAM-1:0]         L0_Clear,
  output logic [Nums_SRAM-1:0]         L0_CS,
  output logic [Nums_SRAM-1:0]         L0_En_W,
  output logic [Nums_SRAM-1:0]         L0_En_R,
  output logic [Weight_Addr_Width-1:0] Mem_Weight_Addr_Read,
  output logic [Input_Addr_Width-1:0]  Mem_Input_Addr_Read,
  output logic [Output_Addr_Width-1:0] Mem_Output_Addr_Write,
  output logic                         L0_Weight_Addr_Write,
  output logic                         L0_Weight_Addr_Read,
  output logic                         L0_Input_Addr_Write,
  output logic                         L0_Input_Addr_Read,
  output logic                         Acc_En,
  output logic                         Acc_Clear
);

  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

  typedef struct packed {
    logic                         valid;
    logic                         slot;
    logic                         first;
    logic                         last;
    logic [Output_Addr_Width-1:0] o;
  } tag_t;

  localparam int Steps = Weight_Nums * Output_Nums;
  localparam logic [Step_Width-1:0]        LastStep = Step_Width'(Steps - 1);
  localparam logic [Weight_Addr_Width-1:0] LastW    = Weight_Addr_Width'(Weight_Nums - 1);

  state_t                        state_r, state_s;
  logic [Weight_Addr_Width-1:0]  w_r, w_s;
  logic [Output_Addr_Width-1:0]  o_r, o_s;
  logic [Step_Width-1:0]         step_r, step_s;
  logic                          slot_r, slot_s;
  logic                          done_s;
  // pipe_r[k] holds the step currently in stage S(k+1); pipe_s[k] is next cycle's S(k+1)
  tag_t                          pipe_r [3];
  tag_t                          pipe_s [4];

  logic                          run_s, wr_s;
  logic [Nums_SRAM-1:0]          mem_clear_s, mem_cs_s, mem_en_w_s, mem_en_r_s;
  logic [Nums_SRAM-1:0]          l0_clear_s, l0_cs_s, l0_en_w_s, l0_en_r_s;
  logic [Weight_Addr_Width-1:0]  w_addr_s;
  logic [Input_Addr_Width-1:0]   in_addr_s;
  logic [Output_Addr_Width-1:0]  out_addr_s;
  logic                          l0_wslot_s, l0_rslot_s;

  // Next-state, step counters and tag pipeline advance
  always_comb begin
    state_s   = state_r;
    w_s       = w_r;
    o_s       = o_r;
    step_s    = step_r;
    slot_s    = slot_r;
    done_s    = 1'b0;
    pipe_s[0] = '0;
    for (int k = 1; k < 4; k++) begin
      pipe_s[k] = pipe_r[k-1];
    end
    case (state_r)
      IDLE: begin
        if (Start && !Done) state_s = CLEAR;
        else                state_s = IDLE;
      end
      CLEAR: begin
        state_s = RUN;
        w_s     = '0;
        o_s     = '0;
        step_s  = '0;
        slot_s  = 1'b0;
      end
      RUN: begin
        pipe_s[0].valid = 1'b1;
        pipe_s[0].slot  = slot_r;
        pipe_s[0].first = (w_r == '0);
        pipe_s[0].last  = (w_r == LastW);
        pipe_s[0].o     = o_r;
        slot_s = ~slot_r;
        step_s = step_r + Step_Width'(1);
        if (w_r == LastW) begin
          w_s = '0;
          o_s = o_r + Output_Addr_Width'(1);
        end else begin
          w_s = w_r + Weight_Addr_Width'(1);
          o_s = o_r;
        end
        if (step_r == LastStep) state_s = DRAIN;
        else                    state_s = RUN;
      end
      DRAIN: begin
        if (!(pipe_s[1].valid || pipe_s[2].valid || pipe_s[3].valid)) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Decode next-cycle controls so every port comes straight from a flop
  always_comb begin
    run_s       = (state_s == RUN);
    wr_s        = pipe_s[3].valid && pipe_s[3].last;
    mem_clear_s = (state_s == CLEAR) ? Nums_SRAM'(3'b100) : Nums_SRAM'(3'b000);
    l0_clear_s  = (state_s == CLEAR) ? Nums_SRAM'(3'b111) : Nums_SRAM'(3'b000);
    mem_en_r_s  = run_s ? Nums_SRAM'(3'b011) : Nums_SRAM'(3'b000);
    mem_en_w_s  = wr_s ? Nums_SRAM'(3'b100) : Nums_SRAM'(3'b000);
    mem_cs_s    = mem_en_r_s | mem_en_w_s;
    l0_en_w_s   = pipe_s[0].valid ? Nums_SRAM'(3'b011) : Nums_SRAM'(3'b000);
    l0_en_r_s   = pipe_s[1].valid ? Nums_SRAM'(3'b011) : Nums_SRAM'(3'b000);
    l0_cs_s     = l0_en_w_s | l0_en_r_s;
    w_addr_s    = run_s ? w_s : Mem_Weight_Addr_Read;
    in_addr_s   = run_s ? (Input_Addr_Width'(o_s) + Input_Addr_Width'(w_s)) : Mem_Input_Addr_Read;
    out_addr_s  = wr_s ? pipe_s[3].o : Mem_Output_Addr_Write;
    l0_wslot_s  = pipe_s[0].valid ? pipe_s[0].slot : L0_Weight_Addr_Write;
    l0_rslot_s  = pipe_s[1].valid ? pipe_s[1].slot : L0_Weight_Addr_Read;
  end

  // FSM, counters and tag pipeline registers
  always_ff @(posedge clk) begin
    if (Mem_Reset) begin
      state_r <= IDLE;
      w_r     <= '0;
      o_r     <= '0;
      step_r  <= '0;
      slot_r  <= 1'b0;
      for (int k = 0; k < 3; k++) pipe_r[k] <= '0;
    end else begin
      state_r <= state_s;
      w_r     <= w_s;
      o_r     <= o_s;
      step_r  <= step_s;
      slot_r  <= slot_s;
      for (int k = 0; k < 3; k++) pipe_r[k] <= pipe_s[k];
    end
  end

  // Registered memory-port controls
  always_ff @(posedge clk) begin
    if (Mem_Reset) begin
      Busy <= 1'b0; Done <= 1'b0; Acc_En <= 1'b0; Acc_Clear <= 1'b0;
      Mem_Clear <= '0; Mem_CS <= '0; Mem_En_W <= '0; Mem_En_R <= '0;
      L0_Clear <= '0; L0_CS <= '0; L0_En_W <= '0; L0_En_R <= '0;
      Mem_Weight_Addr_Read <= '0; Mem_Input_Addr_Read <= '0; Mem_Output_Addr_Write <= '0;
      L0_Weight_Addr_Write <= 1'b0; L0_Input_Addr_Write <= 1'b0;
      L0_Weight_Addr_Read  <= 1'b0; L0_Input_Addr_Read  <= 1'b0;
    end else begin
      Busy <= (state_s != IDLE); Done <= done_s;
      Acc_En <= pipe_s[2].valid; Acc_Clear <= pipe_s[2].valid && pipe_s[2].first;
      Mem_Clear <= mem_clear_s; Mem_CS <= mem_cs_s; Mem_En_W <= mem_en_w_s; Mem_En_R <= mem_en_r_s;
      L0_Clear <= l0_clear_s; L0_CS <= l0_cs_s; L0_En_W <= l0_en_w_s; L0_En_R <= l0_en_r_s;
      Mem_Weight_Addr_Read <= w_addr_s; Mem_Input_Addr_Read <= in_addr_s;
      Mem_Output_Addr_Write <= out_addr_s;
      L0_Weight_Addr_Write <= l0_wslot_s; L0_Input_Addr_Write <= l0_wslot_s;
      L0_Weight_Addr_Read  <= l0_rslot_s; L0_Input_Addr_Read  <= l0_rslot_s;
    end
  end

endmodule

// File: tb/tb_conv1d_mem_scheduler.sv
// Scoreboard bench for conv1d_mem_scheduler: stimulus queues expected events per run,
// a negedge monitor pops and compares them and runs a reference SRAM/L0/MAC model.
module tb_conv1d_mem_scheduler;

  localparam int Steps = 42;

  logic       clk = 1'b0;
  logic       Mem_Reset, Start;
  logic       Busy, Done, Acc_En, Acc_Clear;
  logic [2:0] Mem_Clear, Mem_CS, Mem_En_W, Mem_En_R;
  logic [2:0] L0_Clear, L0_CS, L0_En_W, L0_En_R;
  logic [1:0] Mem_Weight_Addr_Read;
  logic [3:0] Mem_Input_Addr_Read, Mem_Output_Addr_Write;
  logic       L0_Weight_Addr_Write, L0_Weight_Addr_Read, L0_Input_Addr_Write, L0_Input_Addr_Read;

  conv1d_mem_scheduler dut (
    .clk(clk), .Mem_Reset(Mem_Reset), .Start(Start), .Busy(Busy), .Done(Done),
    .Mem_Clear(Mem_Clear), .Mem_CS(Mem_CS), .Mem_En_W(Mem_En_W), .Mem_En_R(Mem_En_R),
    .L0_Clear(L0_Clear), .L0_CS(L0_CS), .L0_En_W(L0_En_W), .L0_En_R(L0_En_R),
    .Mem_Weight_Addr_Read(Mem_Weight_Addr_Read), .Mem_Input_Addr_Read(Mem_Input_Addr_Read),
    .Mem_Output_Addr_Write(Mem_Output_Addr_Write),
    .L0_Weight_Addr_Write(L0_Weight_Addr_Write), .L0_Weight_Addr_Read(L0_Weight_Addr_Read),
    .L0_Input_Addr_Write(L0_Input_Addr_Write), .L0_Input_Addr_Read(L0_Input_Addr_Read),
    .Acc_En(Acc_En), .Acc_Clear(Acc_Clear)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] outs_all;
  assign outs_all = {Busy, Done, Mem_Clear, Mem_CS, Mem_En_W, Mem_En_R, L0_Clear, L0_CS,
                     L0_En_W, L0_En_R, Mem_Weight_Addr_Read, Mem_Input_Addr_Read,
                     Mem_Output_Addr_Write, L0_Weight_Addr_Write, L0_Weight_Addr_Read,
                     L0_Input_Addr_Write, L0_Input_Addr_Read, Acc_En, Acc_Clear};

  typedef struct {int cyc; int a; int b;} ev_t;
  ev_t iss_q[$], s1_q[$], s2_q[$], acc_q[$], wr_q[$], done_q[$];

  int checks = 0, failures = 0, clr_cnt = 0;
  int wmem [4];
  int imem [16];
  int omem [16];
  int rd_w, rd_i, prod, acc;
  int l0w [2];
  int l0i [2];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_ev(input string nm, input ev_t e, input int a, input int b);
    checks++;
    if (e.cyc != cyc || e.a != a || e.b != b) begin
      failures++;
      $display("FAIL %s: got cycle=%0d a=%0d b=%0d, expected cycle=%0d a=%0d b=%0d",
               nm, cyc, a, b, e.cyc, e.a, e.b);
    end
  endtask

  task automatic unexp(input string nm, input int a, input int b);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event at cycle %0d a=%0d b=%0d, expected none", nm, cyc, a, b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Expected event timeline of a full run whose Start is sampled at cycle s
  task automatic push_run(input int s);
    for (int i = 0; i < Steps; i++) begin
      int w, o, sl;
      w = i % 3; o = i / 3; sl = i % 2;
      iss_q.push_back('{s + 2 + i, 60 + w, o + w});
      s1_q.push_back('{s + 3 + i, 3, sl * 3});
      s2_q.push_back('{s + 4 + i, 3, sl * 3});
      acc_q.push_back('{s + 5 + i, (w == 0) ? 1 : 0, 0});
      if (w == 2) wr_q.push_back('{s + 6 + i, 9, o});
    end
    done_q.push_back('{s + 48, 0, 0});
  endtask

  task automatic start_run();
    push_run(cyc);
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic prune(input int lim);
    while (iss_q.size() > 0 && iss_q[$].cyc > lim) void'(iss_q.pop_back());
    while (s1_q.size() > 0 && s1_q[$].cyc > lim) void'(s1_q.pop_back());
    while (s2_q.size() > 0 && s2_q[$].cyc > lim) void'(s2_q.pop_back());
    while (acc_q.size() > 0 && acc_q[$].cyc > lim) void'(acc_q.pop_back());
    while (wr_q.size() > 0 && wr_q[$].cyc > lim) void'(wr_q.pop_back());
    while (done_q.size() > 0 && done_q[$].cyc > lim) void'(done_q.pop_back());
  endtask

  task automatic check_drained();
    chk("pending_issue", iss_q.size(), 0);
    chk("pending_s1", s1_q.size(), 0);
    chk("pending_s2", s2_q.size(), 0);
    chk("pending_acc", acc_q.size(), 0);
    chk("pending_write", wr_q.size(), 0);
    chk("pending_done", done_q.size(), 0);
  endtask

  // Monitor: stages handled oldest first so each one consumes the previous cycle's model state
  initial begin
    ev_t e;
    rd_w = 0; rd_i = 0; prod = 0; acc = 0;
    l0w[0] = 0; l0w[1] = 0; l0i[0] = 0; l0i[1] = 0;
    forever begin
      @(negedge clk);
      if (Done) begin
        if (done_q.size() == 0) unexp("done", int'(Busy), 0);
        else begin e = done_q.pop_front(); chk_ev("done", e, int'(Busy), 0); end
      end
      if (Mem_En_W[2]) begin
        if (wr_q.size() == 0) unexp("out_write", int'({Mem_En_W, Mem_CS[2]}), int'(Mem_Output_Addr_Write));
        else begin e = wr_q.pop_front(); chk_ev("out_write", e, int'({Mem_En_W, Mem_CS[2]}), int'(Mem_Output_Addr_Write)); end
        omem[Mem_Output_Addr_Write] = acc;
      end
      if (Acc_En) begin
        if (acc_q.size() == 0) unexp("acc", int'(Acc_Clear), 0);
        else begin e = acc_q.pop_front(); chk_ev("acc", e, int'(Acc_Clear), 0); end
        if (Acc_Clear) clr_cnt++;
        acc = (Acc_Clear ? 0 : acc) + prod;
      end
      if (L0_En_R[0]) begin
        if (s2_q.size() == 0) unexp("l0_read", int'(L0_En_R), int'({L0_Weight_Addr_Read, L0_Input_Addr_Read}));
        else begin e = s2_q.pop_front(); chk_ev("l0_read", e, int'(L0_En_R), int'({L0_Weight_Addr_Read, L0_Input_Addr_Read})); end
        prod = l0w[L0_Weight_Addr_Read] * l0i[L0_Input_Addr_Read];
      end
      if (L0_En_W[0]) begin
        if (s1_q.size() == 0) unexp("l0_write", int'(L0_En_W), int'({L0_Weight_Addr_Write, L0_Input_Addr_Write}));
        else begin e = s1_q.pop_front(); chk_ev("l0_write", e, int'(L0_En_W), int'({L0_Weight_Addr_Write, L0_Input_Addr_Write})); end
        l0w[L0_Weight_Addr_Write] = rd_w;
        l0i[L0_Input_Addr_Write]  = rd_i;
      end
      if (L0_En_W[0] || L0_En_R[0]) chk("l0_cs", int'(L0_CS), 3);
      if (L0_En_W[0] && L0_En_R[0]) chk("slot_collision", int'(L0_Weight_Addr_Write == L0_Weight_Addr_Read), 0);
      if (Mem_En_R[0]) begin
        if (iss_q.size() == 0) unexp("issue", int'({Mem_En_R, Mem_CS[1:0], Mem_Weight_Addr_Read}), int'(Mem_Input_Addr_Read));
        else begin e = iss_q.pop_front(); chk_ev("issue", e, int'({Mem_En_R, Mem_CS[1:0], Mem_Weight_Addr_Read}), int'(Mem_Input_Addr_Read)); end
        rd_w = wmem[Mem_Weight_Addr_Read];
        rd_i = imem[Mem_Input_Addr_Read];
      end
    end
  end

  initial begin
    int s, clr0;
    wmem[0] = 1; wmem[1] = 2; wmem[2] = 3; wmem[3] = 0;
    for (int k = 0; k < 16; k++) begin imem[k] = k; omem[k] = 0; end
    Mem_Reset = 1'b1; Start = 1'b0;

    // Reset for two cycles, Start coincident with the second one
    step();
    Start = 1'b1;
    step();
    Mem_Reset = 1'b0; Start = 1'b0;
    chk("reset_outputs", $countones(outs_all), 0);
    repeat (5) step();
    chk("idle_busy", int'(Busy), 0);
    chk("idle_outputs", $countones(outs_all), 0);

    // Full run with end-to-end data
    clr0 = clr_cnt;
    s = cyc;
    start_run();
    chk("clear_mem", int'(Mem_Clear), 4);
    chk("clear_l0", int'(L0_Clear), 7);
    chk("clear_busy", int'(Busy), 1);
    wait_until(s + 47);
    chk("drain_busy", int'(Busy), 1);
    wait_until(s + 48);
    chk("done_busy_low", int'(Busy), 0);
    wait_until(s + 52);
    for (int k = 0; k < 14; k++) chk($sformatf("omem[%0d]", k), omem[k], 6 * k + 8);
    chk("acc_clear_count", clr_cnt - clr0, 14);
    check_drained();

    // Start while busy (cycle 5) and coincident with Done (cycle 48) ignored; Start at 49 runs
    s = cyc;
    start_run();
    wait_until(s + 5);
    Start = 1'b1;
    step();
    Start = 1'b0;
    wait_until(s + 48);
    Start = 1'b1;
    step();
    chk("no_clear_after_done_start", int'(Mem_Clear), 0);
    start_run();
    chk("clear_at_50", int'(Mem_Clear), 4);
    wait_until(s + 49 + 52);
    check_drained();

    // Reset mid-run at cycle 20, then a clean run
    s = cyc;
    start_run();
    wait_until(s + 20);
    Mem_Reset = 1'b1;
    step();
    Mem_Reset = 1'b0;
    prune(s + 20);
    chk("midreset_outputs", $countones(outs_all), 0);
    wait_until(s + 70);
    check_drained();
    s = cyc;
    start_run();
    wait_until(s + 52);
    chk("rerun_omem13", omem[13], 86);
    chk("rerun_omem0", omem[0], 8);
    check_drained();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
